// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: FSM encodings, the
// timeout error word, the default timeout and the timer width helper.
`default_nettype none

package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_INST = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [31:0] ERR_WORD        = 32'hDEAD_BEEF;
    localparam int          TIMEOUT_DEFAULT = 255;

    // Counter must hold TIMEOUT-1 and is never narrower than 8 bits.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_timer.sv
// Loadable down-counter for the arbiter's ack timeout; expired is asserted
// while running with the count exhausted.
`default_nettype none

module mem_arb_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = run && (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data ports,
// data first. Optional ack timeout enabled by defining MEM_ARB_TIMEOUT_EN.
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_ren,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic                  inst_valid,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_valid,
    output logic                  ext_req,
    output logic                  ext_we,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    output logic [DATA_WIDTH-1:0] ext_wdata,
    input  logic [DATA_WIDTH-1:0] ext_rdata,
    input  logic                  ext_ack,
    output logic                  bus_err
);

    logic [1:0]            state;
    logic                  busy;
    logic                  timeout_hit;
    logic                  done;
    logic [DATA_WIDTH-1:0] resp_data;

    assign busy = (state == ST_DATA) || (state == ST_INST);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = cnt_width(TIMEOUT);

    mem_arb_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_IDLE),
        .load_val (CW'(TIMEOUT - 1)),
        .run      (busy),
        .expired  (timeout_hit)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    // A real ack always beats a coincident timeout.
    assign done      = ext_ack || timeout_hit;
    assign resp_data = ext_ack ? ext_rdata : DATA_WIDTH'(ERR_WORD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ext_req    <= 1'b0;
            ext_we     <= 1'b0;
            ext_addr   <= '0;
            ext_wdata  <= '0;
            inst_data  <= '0;
            mem_din    <= '0;
            inst_valid <= 1'b0;
            mem_valid  <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_ren || mem_wen) begin
                        state     <= ST_DATA;
                        ext_req   <= 1'b1;
                        ext_we    <= mem_wen;
                        ext_addr  <= mem_addr;
                        ext_wdata <= mem_dout;
                    end else if (inst_ren) begin
                        state    <= ST_INST;
                        ext_req  <= 1'b1;
                        ext_we   <= 1'b0;
                        ext_addr <= inst_addr;
                    end
                end
                ST_DATA, ST_INST: begin
                    if (done) begin
                        state   <= ST_RESP;
                        ext_req <= 1'b0;
                        if (!ext_ack) begin
                            bus_err <= 1'b1;
                        end
                        if (state == ST_DATA) begin
                            mem_valid <= 1'b1;
                            if (!ext_we) begin
                                mem_din <= resp_data;
                            end
                        end else begin
                            inst_valid <= 1'b1;
                            inst_data  <= resp_data;
                        end
                    end
                end
                ST_RESP: begin
                    inst_valid <= 1'b0;
                    mem_valid  <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the timeout scenario
// follows whether MEM_ARB_TIMEOUT_EN is defined.
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_ren = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_data;
    logic        inst_valid;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_dout = '0;
    logic [31:0] mem_din;
    logic        mem_valid;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata = '0;
    logic        ext_ack = 1'b0;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_ren   (inst_ren),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .inst_valid (inst_valid),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .mem_valid  (mem_valid),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_rdata  (ext_rdata),
        .ext_ack    (ext_ack),
        .bus_err    (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set after this are seen at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        repeat (2) tick();
        check("rst_ext_req", {31'd0, ext_req}, 32'd0);
        check("rst_ext_addr", ext_addr, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_valids", {30'd0, inst_valid, mem_valid}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        rst = 1'b1;
        tick();

        // Single fetch, ack two cycles after ext_req rises.
        inst_ren = 1'b1; inst_addr = 32'h40;
        tick();
        check("f1_req", {31'd0, ext_req}, 32'd1);
        check("f1_addr", ext_addr, 32'h40);
        check("f1_we", {31'd0, ext_we}, 32'd0);
        tick();
        tick();
        check("f1_no_early_valid", {31'd0, inst_valid}, 32'd0);
        ext_ack = 1'b1; ext_rdata = 32'h2002_0005;
        tick();
        ext_ack = 1'b0; inst_ren = 1'b0;
        check("f1_valid", {31'd0, inst_valid}, 32'd1);
        check("f1_data", inst_data, 32'h2002_0005);
        check("f1_req_drop", {31'd0, ext_req}, 32'd0);
        tick();
        check("f1_valid_pulse", {31'd0, inst_valid}, 32'd0);
        tick();

        // Simultaneous write and fetch: the write goes first.
        inst_ren = 1'b1; inst_addr = 32'h44;
        mem_wen = 1'b1; mem_addr = 32'h100; mem_dout = 32'hCAFE;
        tick();
        check("wr_req", {31'd0, ext_req}, 32'd1);
        check("wr_we", {31'd0, ext_we}, 32'd1);
        check("wr_addr", ext_addr, 32'h100);
        check("wr_wdata", ext_wdata, 32'hCAFE);
        ext_ack = 1'b1; ext_rdata = 32'h1234_5678;
        tick();
        ext_ack = 1'b0; mem_wen = 1'b0;
        check("wr_valid", {31'd0, mem_valid}, 32'd1);
        check("wr_din_kept", mem_din, 32'd0);
        check("wr_no_inst_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("q_idle_req", {31'd0, ext_req}, 32'd0);
        tick();
        check("q_req", {31'd0, ext_req}, 32'd1);
        check("q_addr", ext_addr, 32'h44);
        check("q_we", {31'd0, ext_we}, 32'd0);
        ext_ack = 1'b1; ext_rdata = 32'h0BAD_F00D;
        tick();
        ext_ack = 1'b0; inst_ren = 1'b0;
        check("q_valid", {31'd0, inst_valid}, 32'd1);
        check("q_data", inst_data, 32'h0BAD_F00D);
        tick();
        tick();

        // Read acked in the same cycle ext_req rises; request held through RESP.
        mem_ren = 1'b1; mem_addr = 32'h200;
        tick();
        check("rd_req", {31'd0, ext_req}, 32'd1);
        ext_ack = 1'b1; ext_rdata = 32'h55AA_1234;
        tick();
        ext_ack = 1'b0;
        check("rd_valid", {31'd0, mem_valid}, 32'd1);
        check("rd_din", mem_din, 32'h55AA_1234);
        tick();
        mem_ren = 1'b0;
        check("rd_idle_no_req", {31'd0, ext_req}, 32'd0);
        check("rd_valid_pulse", {31'd0, mem_valid}, 32'd0);
        tick();
        check("rd_no_dup", {31'd0, ext_req}, 32'd0);

        // Asynchronous reset in the middle of a data write.
        mem_wen = 1'b1; mem_addr = 32'h300; mem_dout = 32'h77;
        tick();
        check("ar_req", {31'd0, ext_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("ar_ext_req", {31'd0, ext_req}, 32'd0);
        check("ar_ext_we", {31'd0, ext_we}, 32'd0);
        check("ar_ext_addr", ext_addr, 32'd0);
        check("ar_ext_wdata", ext_wdata, 32'd0);
        check("ar_inst_data", inst_data, 32'd0);
        check("ar_mem_din", mem_din, 32'd0);
        mem_wen = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        inst_ren = 1'b1; inst_addr = 32'h80;
        tick();
        check("ar_fresh_req", {31'd0, ext_req}, 32'd1);
        check("ar_fresh_addr", ext_addr, 32'h80);
        ext_ack = 1'b1; ext_rdata = 32'hA5A5_0001;
        tick();
        ext_ack = 1'b0; inst_ren = 1'b0;
        check("ar_fresh_valid", {31'd0, inst_valid}, 32'd1);
        check("ar_fresh_data", inst_data, 32'hA5A5_0001);
        tick();
        tick();

        // Read that is never acknowledged.
        mem_ren = 1'b1; mem_addr = 32'h400;
`ifdef MEM_ARB_TIMEOUT_EN
        tick();
        tick();
        tick();
        tick();
        check("to_req_c4", {31'd0, ext_req}, 32'd1);
        check("to_no_err_yet", {31'd0, bus_err}, 32'd0);
        tick();
        mem_ren = 1'b0;
        check("to_req_drop", {31'd0, ext_req}, 32'd0);
        check("to_valid", {31'd0, mem_valid}, 32'd1);
        check("to_din", mem_din, 32'hDEAD_BEEF);
        check("to_bus_err", {31'd0, bus_err}, 32'd1);
        repeat (5) tick();
        check("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ext_req !== 1'b1 || bus_err !== 1'b0) bad++;
        end
        check("nto_hold_cycles_bad", bad, 32'd0);
        check("nto_no_valid", {31'd0, mem_valid}, 32'd0);
        mem_ren = 1'b0;
`endif
        rst = 1'b0;
        tick();
        check("final_bus_err", {31'd0, bus_err}, 32'd0);
        check("final_ext_req", {31'd0, ext_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
